// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: the PPU always wins the RAM, and CPU accesses wait in an
// in-order FIFO until a cycle the PPU leaves idle.
module vram_arbiter #(
  parameter int DEPTH        = 4,
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ppu_req,
  input  logic [ADDR_W-1:0]       ppu_addr,
  output logic [DATA_W-1:0]       ppu_rdata,
  output logic                    ppu_rvalid,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic                    cpu_ready,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_rvalid,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_we,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    starve
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [SC_W-1:0]  SC_ONE   = SC_W'(1'b1);
  localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STARVE_LIMIT);

  logic [ADDR_W-1:0] r_q_addr [DEPTH];
  logic [DATA_W-1:0] r_q_data [DEPTH];
  logic              r_q_we   [DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [SC_W-1:0]   r_starve_cnt;
  logic              r_ppu_rvalid;
  logic              r_cpu_rvalid;

  logic              w_ready;
  logic              w_empty;
  logic              w_push;
  logic              w_ppu_grant;
  logic              w_pop;
  logic              w_cpu_rd_issue;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic              w_head_we;

  assign w_ready     = (r_count != CNT_FULL);
  assign w_empty     = (r_count == CNT_ZERO);
  assign w_push      = cpu_req & w_ready;
  assign w_head_addr = r_q_addr[r_rd_ptr];
  assign w_head_data = r_q_data[r_rd_ptr];
  assign w_head_we   = r_q_we[r_rd_ptr];

  // Grant decision: the PPU is never delayed, the FIFO head only takes idle cycles.
  // Nothing is granted while reset is held, so a reset cycle never touches the RAM.
  always_comb begin
    w_ppu_grant    = 1'b0;
    w_pop          = 1'b0;
    w_cpu_rd_issue = 1'b0;
    mem_addr       = {ADDR_W{1'b0}};
    mem_we         = 1'b0;
    mem_wdata      = {DATA_W{1'b0}};
    if (reset) begin
      w_ppu_grant = 1'b0;
    end else if (ppu_req) begin
      w_ppu_grant = 1'b1;
      mem_addr    = ppu_addr;
    end else if (!w_empty) begin
      w_pop          = 1'b1;
      w_cpu_rd_issue = ~w_head_we;
      mem_addr       = w_head_addr;
      mem_we         = w_head_we;
      mem_wdata      = w_head_data;
    end else begin
      w_pop = 1'b0;
    end
  end

  // FIFO payload storage; contents are don't-care until the count covers them.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_q_addr[r_wr_ptr] <= cpu_addr;
      r_q_data[r_wr_ptr] <= cpu_wdata;
      r_q_we[r_wr_ptr]   <= cpu_we;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= CNT_ZERO;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head-of-queue wait counter, saturating so starve stays asserted.
  always_ff @(posedge clock) begin
    if (reset || w_empty || w_pop) begin
      r_starve_cnt <= {SC_W{1'b0}};
    end else if (r_starve_cnt != SC_MAX) begin
      r_starve_cnt <= r_starve_cnt + SC_ONE;
    end
  end

  // Read-valid flags line up with the one-cycle RAM latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ppu_rvalid <= 1'b0;
      r_cpu_rvalid <= 1'b0;
    end else begin
      r_ppu_rvalid <= w_ppu_grant;
      r_cpu_rvalid <= w_cpu_rd_issue;
    end
  end

  // Masking with reset kills the pulse of a read that was in flight when reset arrived.
  assign ppu_rvalid = r_ppu_rvalid & ~reset;
  assign cpu_rvalid = r_cpu_rvalid & ~reset;
  assign ppu_rdata  = mem_rdata;
  assign cpu_rdata  = mem_rdata;
  assign cpu_ready  = w_ready;
  assign fifo_count = r_count;
  assign starve     = (r_starve_cnt == SC_MAX);

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a behavioural synchronous VRAM.
module tb_vram_arbiter;

  logic        clock;
  logic        reset;
  logic        ppu_req;
  logic [13:0] ppu_addr;
  logic [7:0]  ppu_rdata;
  logic        ppu_rvalid;
  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic [13:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [2:0]  fifo_count;
  logic        starve;

  logic [7:0]  tb_mem [0:16383];
  int          n_cmp;
  int          n_err;

  vram_arbiter #(.DEPTH(4), .ADDR_W(14), .DATA_W(8), .STARVE_LIMIT(16)) dut (
    .clock(clock), .reset(reset),
    .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_rdata(ppu_rdata), .ppu_rvalid(ppu_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fifo_count(fifo_count), .starve(starve)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous single-port RAM, read-before-write, one cycle of read latency.
  always @(posedge clock) begin
    if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    mem_rdata <= tb_mem[mem_addr];
  end

  function automatic logic [7:0] pre(input logic [13:0] a);
    return a[7:0] ^ 8'h3C;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    ppu_req = 1'b0; ppu_addr = 14'h0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 14'h0; cpu_wdata = 8'h0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    repeat (3) tick();
    @(negedge clock);
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata, ppu_rvalid, cpu_rvalid} !== 25'h0) begin
      n_err++;
      $display("FAIL reset_held got we=%b addr=%h wd=%h pv=%b cv=%b expected all 0",
               mem_we, mem_addr, mem_wdata, ppu_rvalid, cpu_rvalid);
    end
    tick();
    reset = 1'b0;
    @(negedge clock);
    n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL rst_cpu_ready got %b exp 1", cpu_ready); end
    n_cmp++; if (ppu_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_ppu_rvalid got %b exp 0", ppu_rvalid); end
    n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_cpu_rvalid got %b exp 0", cpu_rvalid); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL rst_fifo_count got %0d exp 0", fifo_count); end
    n_cmp++; if (starve !== 1'b0) begin n_err++; $display("FAIL rst_starve got %b exp 0", starve); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
    n_cmp++; if (mem_addr !== 14'h0) begin n_err++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 8'h0) begin n_err++; $display("FAIL rst_mem_wdata got %h exp 0", mem_wdata); end
  endtask

  task automatic test_ppu_only;
    for (int c = 0; c < 12; c++) begin
      tick();
      ppu_req  = (c < 10);
      ppu_addr = 14'(c);
      @(negedge clock);
      if (c < 10) begin
        n_cmp++;
        if ({mem_we, mem_addr} !== {1'b0, 14'(c)}) begin
          n_err++; $display("FAIL ppu_mem c%0d got we=%b addr=%h exp we=0 addr=%h", c, mem_we, mem_addr, 14'(c));
        end
      end
      n_cmp++;
      if (ppu_rvalid !== (c >= 1 && c <= 10)) begin
        n_err++; $display("FAIL ppu_rvalid c%0d got %b exp %b", c, ppu_rvalid, (c >= 1 && c <= 10));
      end
      if (c >= 1 && c <= 10) begin
        n_cmp++;
        if (ppu_rdata !== pre(14'(c - 1))) begin
          n_err++; $display("FAIL ppu_rdata c%0d got %h exp %h", c, ppu_rdata, pre(14'(c - 1)));
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_cpu_write_read;
    tick(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h2000; cpu_wdata = 8'hA5;
    @(negedge clock);
    n_cmp++; if ({cpu_ready, mem_we} !== 2'b10) begin n_err++; $display("FAIL wr_accept got ready=%b we=%b exp ready=1 we=0", cpu_ready, mem_we); end
    tick(); cpu_req = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 14'h2000, 8'hA5}) begin
      n_err++; $display("FAIL wr_issue got we=%b addr=%h wd=%h exp we=1 addr=2000 wd=a5", mem_we, mem_addr, mem_wdata);
    end
    n_cmp++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL wr_count got %0d exp 1", fifo_count); end
    tick(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2000;
    @(negedge clock);
    n_cmp++; if ({mem_we, cpu_rvalid} !== 2'b00) begin n_err++; $display("FAIL wr_no_rvalid got we=%b cv=%b exp 0 0", mem_we, cpu_rvalid); end
    tick(); cpu_req = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({mem_we, mem_addr, cpu_rvalid} !== {1'b0, 14'h2000, 1'b0}) begin
      n_err++; $display("FAIL rd_issue got we=%b addr=%h cv=%b exp we=0 addr=2000 cv=0", mem_we, mem_addr, cpu_rvalid);
    end
    tick();
    @(negedge clock);
    n_cmp++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'hA5}) begin
      n_err++; $display("FAIL rd_data got cv=%b data=%h exp cv=1 data=a5", cpu_rvalid, cpu_rdata);
    end
    tick(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0070; cpu_wdata = 8'hE7;
    @(negedge clock);
    n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_single_pulse got %b exp 0", cpu_rvalid); end
    tick(); cpu_req = 1'b0;
    tick(); ppu_req = 1'b1; ppu_addr = 14'h0070;
    tick(); ppu_req = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({ppu_rvalid, ppu_rdata} !== {1'b1, 8'hE7}) begin
      n_err++; $display("FAIL wr_then_ppu got pv=%b data=%h exp pv=1 data=e7", ppu_rvalid, ppu_rdata);
    end
    idle_inputs();
  endtask

  task automatic test_fill;
    for (int c = 0; c < 24; c++) begin
      tick();
      ppu_req   = (c < 20);
      ppu_addr  = 14'h0100;
      cpu_req   = (c < 5);
      cpu_we    = 1'b1;
      cpu_addr  = 14'(16'h3000 + c);
      cpu_wdata = 8'(8'h10 + c);
      @(negedge clock);
      if (c <= 4) begin
        n_cmp++; if (cpu_ready !== (c < 4)) begin n_err++; $display("FAIL fill_ready c%0d got %b exp %b", c, cpu_ready, (c < 4)); end
        n_cmp++; if (fifo_count !== 3'(c)) begin n_err++; $display("FAIL fill_count c%0d got %0d exp %0d", c, fifo_count, c); end
      end
      if (c == 16 || c == 17) begin
        n_cmp++; if (starve !== (c == 17)) begin n_err++; $display("FAIL starve c%0d got %b exp %b", c, starve, (c == 17)); end
      end
      if (c == 19 || c == 20) begin
        n_cmp++;
        if ({fifo_count, cpu_ready} !== {3'd4, 1'b0}) begin
          n_err++; $display("FAIL full_hold c%0d got count=%0d ready=%b exp 4 0", c, fifo_count, cpu_ready);
        end
      end
      if (c < 20) begin
        n_cmp++; if (mem_addr !== 14'h0100) begin n_err++; $display("FAIL fill_ppu_addr c%0d got %h exp 0100", c, mem_addr); end
      end else begin
        n_cmp++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 14'(16'h3000 + c - 20), 8'(8'h10 + c - 20)}) begin
          n_err++; $display("FAIL drain c%0d got we=%b addr=%h wd=%h exp we=1 addr=%h wd=%h", c, mem_we, mem_addr,
                            mem_wdata, 14'(16'h3000 + c - 20), 8'(8'h10 + c - 20));
        end
      end
      if (c == 21) begin
        n_cmp++;
        if ({cpu_ready, starve} !== 2'b10) begin
          n_err++; $display("FAIL drain_ready c21 got ready=%b starve=%b exp 1 0", cpu_ready, starve);
        end
      end
    end
    idle_inputs();
    tick();
    @(negedge clock);
    n_cmp++;
    if ({mem_we, fifo_count} !== 4'h0) begin
      n_err++; $display("FAIL drained got we=%b count=%0d exp 0 0", mem_we, fifo_count);
    end
    n_cmp++; if (tb_mem[14'h3003] !== 8'h13) begin n_err++; $display("FAIL ram_3003 got %h exp 13", tb_mem[14'h3003]); end
    n_cmp++;
    if (tb_mem[14'h3004] !== pre(14'h3004)) begin
      n_err++; $display("FAIL rejected_write got %h exp %h", tb_mem[14'h3004], pre(14'h3004));
    end
  endtask

  task automatic test_interleave;
    logic [13:0] exp_ppu_addr;
    for (int c = 0; c < 3; c++) begin
      tick();
      ppu_req = 1'b1; ppu_addr = 14'h0050;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'(16'h0010 + c);
      @(negedge clock);
    end
    for (int c = 3; c < 10; c++) begin
      tick();
      cpu_req  = 1'b0;
      ppu_req  = (c % 2 == 0) && (c < 9);
      ppu_addr = 14'(16'h0060 + (c - 4) / 2);
      @(negedge clock);
      n_cmp++;
      if (ppu_req) begin
        if ({mem_we, mem_addr} !== {1'b0, ppu_addr}) begin
          n_err++; $display("FAIL il_ppu c%0d got we=%b addr=%h exp we=0 addr=%h", c, mem_we, mem_addr, ppu_addr);
        end
      end else if (c <= 7) begin
        if ({mem_we, mem_addr} !== {1'b0, 14'(16'h0010 + (c - 3) / 2)}) begin
          n_err++; $display("FAIL il_cpu c%0d got we=%b addr=%h exp we=0 addr=%h", c, mem_we, mem_addr,
                            14'(16'h0010 + (c - 3) / 2));
        end
      end else begin
        if ({mem_we, mem_addr} !== 15'h0) begin
          n_err++; $display("FAIL il_idle c%0d got we=%b addr=%h exp 0", c, mem_we, mem_addr);
        end
      end
      n_cmp++;
      if ({ppu_rvalid, cpu_rvalid} !== {(c % 2 == 1), (c % 2 == 0)}) begin
        n_err++; $display("FAIL il_valids c%0d got pv=%b cv=%b exp %b %b", c, ppu_rvalid, cpu_rvalid,
                          (c % 2 == 1), (c % 2 == 0));
      end
      if (c % 2 == 0) begin
        n_cmp++;
        if (cpu_rdata !== pre(14'(16'h0010 + (c - 4) / 2))) begin
          n_err++; $display("FAIL il_cpu_data c%0d got %h exp %h", c, cpu_rdata, pre(14'(16'h0010 + (c - 4) / 2)));
        end
      end else begin
        exp_ppu_addr = (c == 3) ? 14'h0050 : 14'(16'h0060 + (c - 5) / 2);
        n_cmp++;
        if (ppu_rdata !== pre(exp_ppu_addr)) begin
          n_err++; $display("FAIL il_ppu_data c%0d got %h exp %h", c, ppu_rdata, pre(exp_ppu_addr));
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid;
    for (int c = 0; c < 4; c++) begin
      tick();
      ppu_req = 1'b1; ppu_addr = 14'h0040;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'(16'h0020 + c);
      @(negedge clock);
    end
    tick();
    ppu_req = 1'b0; cpu_req = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({mem_we, mem_addr, fifo_count} !== {1'b0, 14'h0020, 3'd4}) begin
      n_err++; $display("FAIL rm_issue got we=%b addr=%h count=%0d exp 0 0020 4", mem_we, mem_addr, fifo_count);
    end
    tick();
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({cpu_rvalid, mem_we, mem_addr} !== 16'h0) begin
      n_err++; $display("FAIL rm_during got cv=%b we=%b addr=%h exp 0", cpu_rvalid, mem_we, mem_addr);
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      n_cmp++;
      if ({cpu_rvalid, mem_we, mem_addr, fifo_count, cpu_ready} !== {1'b0, 1'b0, 14'h0, 3'd0, 1'b1}) begin
        n_err++; $display("FAIL rm_after c%0d got cv=%b we=%b addr=%h count=%0d ready=%b exp 0 0 0 0 1",
                          c, cpu_rvalid, mem_we, mem_addr, fifo_count, cpu_ready);
      end
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int a = 0; a < 16384; a++) tb_mem[a] <= pre(14'(a));
    test_reset();
    test_ppu_only();
    test_cpu_write_read();
    test_fill();
    test_interleave();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port VRAM arbiter between the PPU fetch engine and CPU-side VRAM accesses. The PPU has absolute priority: its fetch is never delayed. CPU reads and writes are queued in a small in-order FIFO and issued only on cycles the PPU leaves the RAM idle. The block sits between the PPU/CPU request ports and the synchronous VRAM (`simram`), replacing direct shared wiring of the RAM address/write lines.

## Interface
Parameters:
- `DEPTH`, 4: CPU request FIFO entries; power of two, ≥2.
- `ADDR_W`, 14: VRAM address width.
- `DATA_W`, 8: VRAM data width.
- `STARVE_LIMIT`, 16: head-of-FIFO wait cycles before `starve` asserts.

Ports:
- `clock`  in  1  single clock for everything.
- `reset`  in  1  synchronous, active-high.
- `ppu_req`  in  1  PPU read request this cycle.
- `ppu_addr`  in  ADDR_W  PPU read address.
- `ppu_rdata`  out  DATA_W  PPU read data; valid when `ppu_rvalid`=1.
- `ppu_rvalid`  out  1  pulses exactly one cycle after a PPU grant.
- `cpu_req`  in  1  CPU request; accepted when `cpu_ready`=1.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_ready`  out  1  FIFO not full (registered count).
- `cpu_rdata`  out  DATA_W  CPU read data; valid when `cpu_rvalid`=1.
- `cpu_rvalid`  out  1  pulses one cycle after a CPU read issues.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_we`  out  1  RAM write enable.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_rdata`  in  DATA_W  RAM read data; one-cycle synchronous latency.
- `fifo_count`  out  log2(DEPTH)+1  queued CPU entries.
- `starve`  out  1  head entry has waited ≥ `STARVE_LIMIT` cycles.

## Operation
- **Accept:** a CPU request is pushed when `cpu_req` & `cpu_ready`. If `cpu_req`=1 while `cpu_ready`=0, the request is not accepted and is not stored. The requester holds it.
- **Grant, per cycle:**
  - `ppu_req`=1: PPU granted. `mem_addr`=`ppu_addr`, `mem_we`=0.
  - Otherwise, if the FIFO is non-empty: the head is issued and popped. `mem_addr`=head address; `mem_we`=head `we`; `mem_wdata`=head data.
  - Otherwise idle: `mem_addr`=0, `mem_we`=0, `mem_wdata`=0.
- **Data paths:** `mem_*` outputs are combinational from the grant decision and registered FIFO state. `ppu_rdata` and `cpu_rdata` pass `mem_rdata` through.
- **Valid flags:**
  - `ppu_rvalid` is the PPU grant, registered.
  - `cpu_rvalid` is "CPU read issued", registered. It is never raised for writes.
- **Ordering:** CPU requests issue strictly in acceptance order. RAM access order equals issue order, so a CPU write issued before a PPU read of the same address is visible to that read.
- **FIFO and count:**
  - There is no bypass: an entry pushed in cycle N is eligible in cycle N+1 at the earliest.
  - Push and pop in the same cycle leave the count unchanged.
  - `cpu_ready` = (`fifo_count` != DEPTH), evaluated from the registered count. A pop in the same cycle does not make a full FIFO ready.
  - Pointers wrap modulo DEPTH.
- **Starvation counter:**
  - Clears when the FIFO is empty or the head issues.
  - Otherwise increments each cycle, saturating at `STARVE_LIMIT`.
  - `starve` = (counter == `STARVE_LIMIT`). It is diagnostic only; priority does not change.
- **Reset:** pointers, count, starve counter and valid flags are cleared. Queued entries are discarded. A read in flight at reset produces no valid pulse.

## Timing
- **Reset values:** `cpu_ready`=1; `ppu_rvalid`=0; `cpu_rvalid`=0; `fifo_count`=0; `starve`=0; `mem_we`=0; `mem_addr`=0; `mem_wdata`=0.
- **PPU read latency:** request in cycle N, data with `ppu_rvalid` in N+1. PPU back-to-back requests every cycle are sustained.
- **CPU minimum latency:** accepted in N, issued in N+1, read data with `cpu_rvalid` in N+2.
- **CPU throughput:** one issue per cycle the PPU is idle.

## Test plan
- **Reset state:** hold reset 3 cycles, then release. All outputs are at their reset values; `mem_we`=0.
- **PPU only:** `ppu_req` for 10 consecutive cycles with preloaded addresses 0x0000..0x0009. `ppu_rvalid` is high in cycles 1..10 with matching data; `mem_we` stays 0.
- **CPU write then read:**
  - Write 0xA5 to 0x2000 with PPU idle: `mem_we`=1 with addr 0x2000 one cycle after accept.
  - Then read 0x2000: `cpu_rvalid` with 0xA5 two cycles after accept.
- **Fill under PPU load:** `ppu_req` held high and 5 CPU writes offered.
  - 4 are accepted; `fifo_count`=4 and `cpu_ready`=0.
  - `starve` asserts 16 cycles after the first push.
  - On `ppu_req` drop, the 4 writes issue in order over 4 cycles and `cpu_ready` returns to 1.
- **Interleave:** alternate `ppu_req` 1/0 with 3 queued CPU reads. CPU reads issue only on `ppu_req`=0 cycles, in order; each `cpu_rvalid` follows its issue by 1 cycle, and valid flags are never both high for the same cycle's data.
- **Reset mid-operation:** assert reset with 3 queued entries and a CPU read issued the prior cycle. No `cpu_rvalid` pulse follows; `fifo_count`=0 and nothing further issues.
